// File: rtl/fifo_pkg.sv
// Shared defaults for the SSP transmit/receive word queue.
package fifo_pkg;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/fifo_if.sv
// Single-port queue bus: op enable/select and push data in, pop data and flags out.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) ();
    logic             en;
    logic             rw;      // 0 = pop, 1 = push
    logic [WIDTH-1:0] wordIn;
    logic [WIDTH-1:0] wordOut;
    logic             intr;    // full
    logic             nempty;  // at least one word held

    modport master (output en, rw, wordIn, input wordOut, intr, nempty);
    modport slave  (input en, rw, wordIn, output wordOut, intr, nempty);
endinterface

// File: rtl/fifo.sv
// DEPTH x WIDTH word queue with one read-or-write operation per enabled cycle.
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input logic   pclk,
    input logic   clear,
    fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] word_q;
    logic             full, empty, do_wr, do_rd;

    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);
    // Writes to a full queue and reads from an empty one are silently dropped.
    assign do_wr  = bus.en &  bus.rw & ~full;
    assign do_rd  = bus.en & ~bus.rw & ~empty;

    assign bus.wordOut = word_q;
    assign bus.intr    = full;
    assign bus.nempty  = ~empty;

    // Storage array; no reset, stale entries are never visible because count gates reads.
    always_ff @(posedge pclk) begin
        if (do_wr) mem[wr_ptr] <= bus.wordIn;
    end

    // Pointers, occupancy and the registered pop data; clear empties the queue at once.
    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            word_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (do_rd) begin
                word_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo.sv
// Directed bench for the 4 x 8 word queue: a vector table plus async-clear sequences.
module tb_fifo;
    logic pclk;
    logic clear;
    int   n_cmp;
    int   n_bad;

    fifo_if #(.WIDTH(8)) bus ();

    fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .pclk  (pclk),
        .clear (clear),
        .bus   (bus)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    typedef struct {
        logic       clr;
        logic       en;
        logic       rw;
        logic [7:0] din;
        logic [7:0] eout;
        logic       eintr;
        logic       ene;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [7:0] eout, input logic eintr, input logic ene);
        chk({nm, ".wordOut"}, bus.wordOut, eout);
        chk({nm, ".intr"}, {7'd0, bus.intr}, {7'd0, eintr});
        chk({nm, ".nempty"}, {7'd0, bus.nempty}, {7'd0, ene});
    endtask

    // One synchronous operation: drive at negedge, sample 1ns after the rising edge.
    task automatic op(input logic c, input logic e, input logic r, input logic [7:0] d);
        @(negedge pclk);
        clear     = c;
        bus.en    = e;
        bus.rw    = r;
        bus.wordIn = d;
        @(posedge pclk);
        #1;
    endtask

    function automatic void add(input logic c, input logic e, input logic r, input logic [7:0] d,
                                input logic [7:0] eo, input logic ei, input logic en_, input string nm);
        vec_t v;
        v.clr = c; v.en = e; v.rw = r; v.din = d;
        v.eout = eo; v.eintr = ei; v.ene = en_; v.nm = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear = 1'b1;
        bus.en = 1'b0;
        bus.rw = 1'b0;
        bus.wordIn = 8'h00;

        //   clr en rw din    out   intr ne
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, "reset");
        add(0, 1, 0, 8'h00, 8'h00, 0, 0, "rd_empty");
        add(0, 1, 1, 8'h63, 8'h00, 0, 1, "fill0");
        add(0, 1, 1, 8'h61, 8'h00, 0, 1, "fill1");
        add(0, 1, 1, 8'h74, 8'h00, 0, 1, "fill2");
        add(0, 1, 1, 8'h73, 8'h00, 1, 1, "fill3");
        add(0, 1, 1, 8'h62, 8'h00, 1, 1, "overflow");
        add(0, 0, 1, 8'hAA, 8'h00, 1, 1, "en_off0");
        add(0, 0, 1, 8'h55, 8'h00, 1, 1, "en_off1");
        add(0, 1, 0, 8'h00, 8'h63, 0, 1, "drain0");
        add(0, 1, 0, 8'h00, 8'h61, 0, 1, "drain1");
        add(0, 1, 0, 8'h00, 8'h74, 0, 1, "drain2");
        add(0, 1, 0, 8'h00, 8'h73, 0, 0, "drain3");
        add(0, 1, 0, 8'h00, 8'h73, 0, 0, "rd_under");
        // offset the pointers by one so the next fill wraps mid-array
        add(0, 1, 1, 8'h11, 8'h73, 0, 1, "skew_wr");
        add(0, 1, 0, 8'h00, 8'h11, 0, 0, "skew_rd");
        add(0, 1, 1, 8'h62, 8'h11, 0, 1, "wrap_w0");
        add(0, 1, 1, 8'h69, 8'h11, 0, 1, "wrap_w1");
        add(0, 1, 1, 8'h72, 8'h11, 0, 1, "wrap_w2");
        add(0, 1, 1, 8'h64, 8'h11, 1, 1, "wrap_w3");
        add(0, 0, 0, 8'h00, 8'h11, 1, 1, "en_off_rd");
        add(0, 1, 0, 8'h00, 8'h62, 0, 1, "wrap_r0");
        add(0, 1, 0, 8'h00, 8'h69, 0, 1, "wrap_r1");
        add(0, 1, 0, 8'h00, 8'h72, 0, 1, "wrap_r2");
        add(0, 1, 0, 8'h00, 8'h64, 0, 0, "wrap_r3");
        add(0, 1, 1, 8'h73, 8'h64, 0, 1, "wrap_w4");
        add(0, 1, 0, 8'h00, 8'h73, 0, 0, "wrap_r4");

        for (int i = 0; i < vecs.size(); i++) begin
            op(vecs[i].clr, vecs[i].en, vecs[i].rw, vecs[i].din);
            check_all(vecs[i].nm, vecs[i].eout, vecs[i].eintr, vecs[i].ene);
        end

        // Async clear between edges with two words queued and wordOut non-zero.
        op(0, 1, 1, 8'h5A);
        op(0, 1, 1, 8'hA5);
        check_all("two_queued", 8'h73, 1'b0, 1'b1);
        @(negedge pclk);
        bus.en = 1'b0;
        #2 clear = 1'b1;
        #1 check_all("async_clr2", 8'h00, 1'b0, 1'b0);
        op(0, 1, 0, 8'h00);
        check_all("after_clr_rd", 8'h00, 1'b0, 1'b0);

        // Async clear while full: intr must fall without a clock edge.
        op(0, 1, 1, 8'h01);
        op(0, 1, 1, 8'h02);
        op(0, 1, 1, 8'h03);
        op(0, 1, 1, 8'h04);
        op(0, 1, 0, 8'h00);
        op(0, 1, 1, 8'h05);
        check_all("refull", 8'h01, 1'b1, 1'b1);
        @(negedge pclk);
        bus.en = 1'b0;
        #2 clear = 1'b1;
        #1 check_all("async_clr_full", 8'h00, 1'b0, 1'b0);
        op(0, 1, 1, 8'hC3);
        op(0, 1, 0, 8'h00);
        check_all("post_clr_fifo", 8'hC3, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
